branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 103 ++++++++++
 tb/tb_branch_resolve.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch resolution stage: carries fetch-time predictions to EX, detects mispredicts,
// flushes and redirects fetch, then drains two slots. Counters gated by BRANCH_RESOLVE_STATS_EN.
module branch_resolve (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] pc_4_if,
    input  logic [1:0]  binary_predict_if,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        update_en,
    output logic [31:0] pc_4_id_ex,
    output logic [31:0] branch_jump_addr,
    output logic [1:0]  binary_predict_id_ex,
    output logic        jp_success,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        recovering
`ifdef BRANCH_RESOLVE_STATS_EN
   ,output logic [15:0] branch_cnt,
    output logic [15:0] mispredict_cnt
`endif
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_4;
        logic [1:0]  predict;
    } slot_t;

    typedef enum logic {RUN, RECOVER} state_t;

    localparam slot_t SLOT_RST = '{valid: 1'b0, pc_4: 32'd0, predict: 2'b01};

    slot_t  if_id, id_ex;
    state_t state;
    logic [1:0] drain;
    logic ex_valid, pred_taken, mispredict;

    assign ex_valid             = id_ex.valid & ex_is_branch & (state == RUN);
    assign update_en            = ex_valid & en;
    assign pc_4_id_ex           = id_ex.pc_4;
    assign binary_predict_id_ex = id_ex.predict;
    assign branch_jump_addr     = ex_target;
    assign jp_success           = ex_taken;
    assign pred_taken           = id_ex.predict[1];
    assign mispredict           = ex_valid & (pred_taken != ex_taken);
    assign flush                = mispredict & en;
    assign redirect_pc          = ex_taken ? ex_target : id_ex.pc_4;
    assign recovering           = (state == RECOVER);

    // A flush only kills the valids; stale pc/predict are harmless once invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id <= SLOT_RST;
            id_ex <= SLOT_RST;
        end else if (en) begin
            if (flush) begin
                if_id.valid <= 1'b0;
                id_ex.valid <= 1'b0;
            end else begin
                if_id <= '{valid: 1'b1, pc_4: pc_4_if, predict: binary_predict_if};
                id_ex <= if_id;
            end
        end
    end

    // RECOVER masks resolution until the two squashed slots have drained out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            drain <= 2'd0;
        end else if (en) begin
            case (state)
                RUN: begin
                    if (flush) begin
                        state <= RECOVER;
                        drain <= 2'd2;
                    end
                end
                RECOVER: begin
                    drain <= drain - 2'd1;
                    if (drain == 2'd1) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt     <= 16'd0;
            mispredict_cnt <= 16'd0;
        end else begin
            if (update_en && branch_cnt != 16'hFFFF)  branch_cnt     <= branch_cnt + 16'd1;
            if (flush && mispredict_cnt != 16'hFFFF)  mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: predict/resolve scenarios, stall, recovery drain, reset abort.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [31:0] pc_4_if;
    logic [1:0]  binary_predict_if;
    logic        ex_is_branch, ex_taken;
    logic [31:0] ex_target;
    logic        update_en, jp_success, flush, recovering;
    logic [31:0] pc_4_id_ex, branch_jump_addr, redirect_pc;
    logic [1:0]  binary_predict_id_ex;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [15:0] branch_cnt, mispredict_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk(clk), .rst(rst), .en(en),
        .pc_4_if(pc_4_if), .binary_predict_if(binary_predict_if),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
        .update_en(update_en), .pc_4_id_ex(pc_4_id_ex), .branch_jump_addr(branch_jump_addr),
        .binary_predict_id_ex(binary_predict_id_ex), .jp_success(jp_success),
        .flush(flush), .redirect_pc(redirect_pc), .recovering(recovering)
`ifdef BRANCH_RESOLVE_STATS_EN
       ,.branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Put an instruction into ID/EX with EX resolution idle while it travels.
    task automatic load(input logic [31:0] pc, input logic [1:0] pred);
        ex_is_branch      = 1'b0;
        pc_4_if           = pc;
        binary_predict_if = pred;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; pc_4_if = 32'h0; binary_predict_if = 2'b00;
        ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h0;
        #1;
        chk("rst_update_en", update_en, 0);
        chk("rst_flush", flush, 0);
        chk("rst_recovering", recovering, 0);
        chk("rst_predict", binary_predict_id_ex, 2'b01);
        chk("rst_pc4", pc_4_id_ex, 0);
        step(); step();
        rst = 1'b0;

        // Correct taken prediction
        load(32'h104, 2'b11);
        ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h200;
        #1;
        chk("hit_update_en", update_en, 1);
        chk("hit_jp_success", jp_success, 1);
        chk("hit_flush", flush, 0);
        chk("hit_pc4", pc_4_id_ex, 32'h104);
        chk("hit_addr", branch_jump_addr, 32'h200);
        chk("hit_predict", binary_predict_id_ex, 2'b11);

        // Predicted not-taken, actually taken
        load(32'h110, 2'b01);
        ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h300;
        pc_4_if = 32'h114; binary_predict_if = 2'b11;
        #1;
        chk("mp_flush", flush, 1);
        chk("mp_redirect", redirect_pc, 32'h300);
        chk("mp_update_en", update_en, 1);
        step();
        chk("rc0_recovering", recovering, 1);
        chk("rc0_update_en", update_en, 0);
        chk("rc0_flush", flush, 0);
        en = 1'b0;
        step();
        chk("rc_stall_recovering", recovering, 1);
        en = 1'b1;
        step();
        chk("rc1_recovering", recovering, 1);
        chk("rc1_update_en", update_en, 0);
        step();
        chk("rc2_recovering", recovering, 0);
        chk("rc2_update_en", update_en, 1);
        chk("rc2_flush", flush, 0);
        chk("rc2_pc4", pc_4_id_ex, 32'h114);

        // Predicted taken, actually not taken
        load(32'h108, 2'b10);
        ex_is_branch = 1'b1; ex_taken = 1'b0; ex_target = 32'h500;
        #1;
        chk("nt_flush", flush, 1);
        chk("nt_redirect", redirect_pc, 32'h108);
        chk("nt_predict", binary_predict_id_ex, 2'b10);
        step();
        ex_is_branch = 1'b0;
        step(); step();
        chk("nt_drained", recovering, 0);

        // Non-branch in EX with a would-be mispredict
        load(32'h130, 2'b00);
        ex_taken = 1'b1;
        #1;
        chk("nb_flush", flush, 0);
        chk("nb_update_en", update_en, 0);

        // Mispredict held pending across a 3-cycle stall
        load(32'h120, 2'b00);
        en = 1'b0;
        ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h400;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_flush", i), flush, 0);
            chk($sformatf("stall%0d_update_en", i), update_en, 0);
            step();
        end
        en = 1'b1;
        #1;
        chk("unstall_flush", flush, 1);
        chk("unstall_redirect", redirect_pc, 32'h400);
        step();
        chk("abort_pre_recovering", recovering, 1);
        step();
        chk("abort_mid_recovering", recovering, 1);

        // Reset mid-RECOVER
        rst = 1'b1;
        #1;
        chk("abort_recovering", recovering, 0);
        chk("abort_update_en", update_en, 0);
        chk("abort_pc4", pc_4_id_ex, 0);
        chk("abort_predict", binary_predict_id_ex, 2'b01);
        rst = 1'b0;
        #1;
        chk("abort_invalid_update", update_en, 0);
        chk("abort_invalid_flush", flush, 0);

`ifdef BRANCH_RESOLVE_STATS_EN
        pc_4_if = 32'h140; binary_predict_if = 2'b11;
        ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h600;
        repeat (70000) step();
        chk("stats_branch_sat", branch_cnt, 16'hFFFF);
        chk("stats_mispredict", mispredict_cnt, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
